// File: rtl/dmi_debug_module.sv
`default_nettype none
// ============================================================================
// Module   : dmi_debug_module
// Purpose  : DMI request/response slave with a minimal RISC-V debug register
//            set and abstract register-access command engine.
// Revision : 1.0 - initial release
// ============================================================================
module dmi_debug_module #(
    parameter int RESP_LATENCY       = 1,
    parameter int IDLE_CYCLES_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  dmi_addr,
    input  logic [31:0] dmi_wdata,
    input  logic [1:0]  dmi_op,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    output logic [31:0] dmi_rdata,
    output logic [1:0]  dmi_resp,
    output logic        haltreq,
    output logic        resumereq,
    output logic        ndmreset,
    input  logic        hart_halted,
    input  logic        hart_resumeack,
    output logic        reg_req,
    output logic        reg_write,
    output logic [15:0] reg_regno,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic A_IDLE = 1'b0;
    localparam logic A_REQ  = 1'b1;

    localparam logic [1:0] C_OP_READ  = 2'd1;
    localparam logic [1:0] C_OP_WRITE = 2'd2;
    localparam logic [1:0] C_OP_RSVD  = 2'd3;

    localparam logic [6:0] C_ADDR_DATA0  = 7'h04;
    localparam logic [6:0] C_ADDR_DATA1  = 7'h05;
    localparam logic [6:0] C_ADDR_DMCTL  = 7'h10;
    localparam logic [6:0] C_ADDR_DMSTAT = 7'h11;
    localparam logic [6:0] C_ADDR_ACS    = 7'h16;
    localparam logic [6:0] C_ADDR_CMD    = 7'h17;

    localparam int         C_WAIT_INT  = (RESP_LATENCY >= 2) ? (RESP_LATENCY - 2) : 0;
    localparam logic [3:0] C_WAIT_INIT = C_WAIT_INT[3:0];

    logic        unused_tie;
    assign unused_tie = (IDLE_CYCLES_UNUSED != 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic        haltreq_q, haltreq_d;
    logic        resumereq_q, resumereq_d;
    logic        resumeack_q, resumeack_d;
    logic        ndmreset_q, ndmreset_d;
    logic        dmactive_q, dmactive_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        a_state_q, a_state_d;
    logic [15:0] regno_q, regno_d;
    logic        write_q, write_d;

    logic        busy;
    logic        exec;
    logic        is_read;
    logic        is_write;
    logic        data_acc;
    logic [31:0] rd_val;
    logic [1:0]  resp_now;

    // DMI FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 7'd0;
            wdata_q <= 32'd0;
            op_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
        end
    end

    // DMI FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (dmi_req_valid && (dmi_op != 2'd0)) begin
                    addr_d  = dmi_addr;
                    wdata_d = dmi_wdata;
                    op_d    = dmi_op;
                    if (RESP_LATENCY <= 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // DMI FSM: outputs
    always_comb begin
        exec          = (state_q == S_RESP);
        dmi_req_ready = exec;
    end

    assign busy     = (a_state_q == A_REQ);
    assign is_read  = exec && (op_q == C_OP_READ);
    assign is_write = exec && (op_q == C_OP_WRITE);
    assign data_acc = (is_read || is_write) && busy &&
                      ((addr_q == C_ADDR_DATA0) || (addr_q == C_ADDR_DATA1));
    assign resp_now = (op_q == C_OP_RSVD) ? 2'd2 : 2'd0;

    always_comb begin
        rd_val = 32'd0;
        case (addr_q)
            C_ADDR_DATA0:  rd_val = busy ? 32'd0 : data0_q;
            C_ADDR_DATA1:  rd_val = busy ? 32'd0 : data1_q;
            C_ADDR_DMCTL:  rd_val = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
            C_ADDR_DMSTAT: rd_val = {14'd0, {2{resumeack_q}}, 4'd0, {2{~hart_halted}},
                                     {2{hart_halted}}, 1'b1, 3'd0, 4'd2};
            C_ADDR_ACS:    rd_val = {19'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd2};
            default:       rd_val = 32'd0;
        endcase
    end

    // Response data is live during the strobe cycle and held afterwards
    assign dmi_rdata = is_read ? rd_val : rdata_q;
    assign dmi_resp  = exec ? resp_now : resp_q;

    always_comb begin
        rdata_d     = is_read ? rd_val : rdata_q;
        resp_d      = exec ? resp_now : resp_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        haltreq_d   = haltreq_q;
        resumereq_d = resumereq_q;
        resumeack_d = resumeack_q;
        ndmreset_d  = ndmreset_q;
        dmactive_d  = dmactive_q;
        cmderr_d    = cmderr_q;
        a_state_d   = a_state_q;
        regno_d     = regno_q;
        write_d     = write_q;

        if (hart_resumeack && resumereq_q) begin
            resumereq_d = 1'b0;
            resumeack_d = 1'b1;
        end

        if (busy && reg_ack) begin
            a_state_d = A_IDLE;
            if (!write_q) data0_d = reg_rdata;
        end

        if (data_acc && (cmderr_q == 3'd0)) cmderr_d = 3'd1;

        if (is_write) begin
            if (addr_q == C_ADDR_DMCTL) begin
                if (!wdata_q[0]) begin
                    // Deactivation wipes debug state and aborts any transfer
                    dmactive_d  = 1'b0;
                    data0_d     = 32'd0;
                    data1_d     = 32'd0;
                    cmderr_d    = 3'd0;
                    haltreq_d   = 1'b0;
                    ndmreset_d  = 1'b0;
                    resumereq_d = 1'b0;
                    a_state_d   = A_IDLE;
                end else begin
                    dmactive_d = 1'b1;
                    haltreq_d  = wdata_q[31];
                    ndmreset_d = wdata_q[1];
                    if (wdata_q[30] && hart_halted) begin
                        resumereq_d = 1'b1;
                        resumeack_d = 1'b0;
                    end
                end
            end else if (dmactive_q) begin
                case (addr_q)
                    C_ADDR_DATA0: if (!busy) data0_d = wdata_q;
                    C_ADDR_DATA1: if (!busy) data1_d = wdata_q;
                    C_ADDR_ACS:   cmderr_d = cmderr_q & ~wdata_q[10:8];
                    C_ADDR_CMD: begin
                        if (cmderr_q != 3'd0) begin
                            cmderr_d = cmderr_q;
                        end else if (busy) begin
                            cmderr_d = 3'd1;
                        end else if ((wdata_q[31:24] != 8'd0) || (wdata_q[22:20] != 3'd2)) begin
                            cmderr_d = 3'd2;
                        end else if (!hart_halted) begin
                            cmderr_d = 3'd4;
                        end else if (wdata_q[17]) begin
                            a_state_d = A_REQ;
                            regno_d   = wdata_q[15:0];
                            write_d   = wdata_q[16];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q     <= 32'd0;
            resp_q      <= 2'd0;
            data0_q     <= 32'd0;
            data1_q     <= 32'd0;
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            resumeack_q <= 1'b0;
            ndmreset_q  <= 1'b0;
            dmactive_q  <= 1'b0;
            cmderr_q    <= 3'd0;
            a_state_q   <= A_IDLE;
            regno_q     <= 16'd0;
            write_q     <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            resumeack_q <= resumeack_d;
            ndmreset_q  <= ndmreset_d;
            dmactive_q  <= dmactive_d;
            cmderr_q    <= cmderr_d;
            a_state_q   <= a_state_d;
            regno_q     <= regno_d;
            write_q     <= write_d;
        end
    end

    assign haltreq   = haltreq_q;
    assign resumereq = resumereq_q;
    assign ndmreset  = ndmreset_q;
    assign reg_req   = busy;
    assign reg_write = busy & write_q;
    assign reg_regno = regno_q;
    assign reg_wdata = busy ? data0_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmi_debug_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_debug_module
// Purpose  : Directed scoreboard bench for dmi_debug_module (latency 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_debug_module;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [1:0]  dmi_op;
    logic        dmi_req_valid, valid2;
    logic        hart_halted, hart_resumeack;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    logic        dmi_req_ready, ready2;
    logic [31:0] dmi_rdata, rdata2;
    logic [1:0]  dmi_resp, resp2;
    logic        haltreq, resumereq, ndmreset;
    logic        reg_req, reg_write;
    logic [15:0] reg_regno;
    logic [31:0] reg_wdata;
    logic        haltreq2, resumereq2, ndmreset2, reg_req2, reg_write2;
    logic [15:0] reg_regno2;
    logic [31:0] reg_wdata2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          chk_rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmi_debug_module #(.RESP_LATENCY(1), .IDLE_CYCLES_UNUSED(0)) u_dut (
        .clk(clk), .rst(rst), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
        .dmi_op(dmi_op), .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp), .haltreq(haltreq),
        .resumereq(resumereq), .ndmreset(ndmreset), .hart_halted(hart_halted),
        .hart_resumeack(hart_resumeack), .reg_req(reg_req), .reg_write(reg_write),
        .reg_regno(reg_regno), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack)
    );

    dmi_debug_module #(.RESP_LATENCY(4), .IDLE_CYCLES_UNUSED(0)) u_dut4 (
        .clk(clk), .rst(rst2), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
        .dmi_op(dmi_op), .dmi_req_valid(valid2), .dmi_req_ready(ready2),
        .dmi_rdata(rdata2), .dmi_resp(resp2), .haltreq(haltreq2),
        .resumereq(resumereq2), .ndmreset(ndmreset2), .hart_halted(hart_halted),
        .hart_resumeack(hart_resumeack), .reg_req(reg_req2), .reg_write(reg_write2),
        .reg_regno(reg_regno2), .reg_wdata(reg_wdata2), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One DMI transaction on the latency-1 instance; returns one cycle after
    // the strobe so that register side effects are visible.
    task automatic txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input bit chk_rd, input logic [1:0] exp_resp);
        exp_t e;
        int   cyc;
        bit   got;
        sb.push_back('{rdata: exp_rd, resp: exp_resp, chk_rd: chk_rd});
        dmi_op        = op;
        dmi_addr      = addr;
        dmi_wdata     = wd;
        dmi_req_valid = 1'b1;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (dmi_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        dmi_req_valid = 1'b0;
        dmi_op        = 2'd0;
        chk({tag, "_latency"}, got ? cyc : 32'hDEAD, 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_resp"}, {30'd0, dmi_resp}, {30'd0, e.resp});
            if (e.chk_rd) chk({tag, "_rdata"}, dmi_rdata, e.rdata);
        end
        step();
    endtask

    task automatic wr(input string tag, input logic [6:0] addr, input logic [31:0] wd);
        txn(tag, 2'd2, addr, wd, 32'd0, 1'b0, 2'd0);
    endtask

    task automatic rd(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        txn(tag, 2'd1, addr, 32'd0, exp, 1'b1, 2'd0);
    endtask

    initial begin
        int cnt;
        int cyc;
        bit got;
        exp_t e;
        rst = 1'b1; rst2 = 1'b1;
        dmi_addr = 7'd0; dmi_wdata = 32'd0; dmi_op = 2'd0;
        dmi_req_valid = 1'b0; valid2 = 1'b0;
        hart_halted = 1'b0; hart_resumeack = 1'b0;
        reg_rdata = 32'd0; reg_ack = 1'b0;
        repeat (3) step();

        chk("rst_ready",  {31'd0, dmi_req_ready}, 32'd0);
        chk("rst_resp",   {30'd0, dmi_resp}, 32'd0);
        chk("rst_rdata",  dmi_rdata, 32'd0);
        chk("rst_ctrl",   {29'd0, haltreq, resumereq, ndmreset}, 32'd0);
        chk("rst_regreq", {30'd0, reg_req, reg_write}, 32'd0);
        chk("rst_regno",  {16'd0, reg_regno}, 32'd0);
        chk("rst_wdata",  reg_wdata, 32'd0);
        rst = 1'b0; rst2 = 1'b0;
        step();

        // Inactive module ignores data writes
        wr("w_inactive", 7'h04, 32'h11111111);
        rd("r_inactive", 7'h04, 32'd0);

        wr("w_dmactive", 7'h10, 32'h00000001);
        wr("w_data0", 7'h04, 32'hDEADBEEF);
        rd("r_data0", 7'h04, 32'hDEADBEEF);
        wr("w_data1", 7'h05, 32'hCAFEF00D);
        rd("r_data1", 7'h05, 32'hCAFEF00D);
        wr("w_unmapped", 7'h20, 32'hFFFFFFFF);
        rd("r_unmapped", 7'h20, 32'd0);
        txn("op3", 2'd3, 7'h04, 32'h0, 32'd0, 1'b0, 2'd2);
        rd("r_data0_after_op3", 7'h04, 32'hDEADBEEF);
        rd("r_command", 7'h17, 32'd0);

        hart_halted = 1'b1;
        rd("r_dmstatus_halted", 7'h11, 32'h00000382);
        wr("w_haltreq", 7'h10, 32'h80000001);
        chk("haltreq_out", {31'd0, haltreq}, 32'd1);
        rd("r_dmcontrol", 7'h10, 32'h80000001);

        // Abstract read of regno 0x1005, acked in the third reg_req cycle
        wr("w_cmd_read", 7'h17, 32'h00221005);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (reg_req) begin
                cnt++;
                if (cnt == 1) begin
                    chk("cmd_regno", {16'd0, reg_regno}, 32'h00001005);
                    chk("cmd_regwrite", {31'd0, reg_write}, 32'd0);
                end
                if (cnt == 3) begin
                    reg_ack   = 1'b1;
                    reg_rdata = 32'h12345678;
                end
            end
            step();
            reg_ack = 1'b0;
            if (!reg_req && cnt > 0) break;
        end
        chk("reg_req_cycles", cnt, 32'd3);
        rd("r_data0_loaded", 7'h04, 32'h12345678);
        rd("r_acs_idle", 7'h16, 32'h00000002);

        reg_rdata = 32'hFFFFFFFF;
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        rd("r_data0_stray_ack", 7'h04, 32'h12345678);

        // Abstract write held busy while the bus pokes at it
        wr("w_cmd_write", 7'h17, 32'h00231005);
        chk("busy_regreq", {31'd0, reg_req}, 32'd1);
        chk("busy_regwrite", {31'd0, reg_write}, 32'd1);
        chk("busy_regwdata", reg_wdata, 32'h12345678);
        chk("busy_regno", {16'd0, reg_regno}, 32'h00001005);
        rd("r_acs_busy", 7'h16, 32'h00001002);
        wr("w_cmd_busy", 7'h17, 32'h00231005);
        rd("r_acs_cmderr1", 7'h16, 32'h00001102);
        rd("r_data0_busy", 7'h04, 32'd0);
        wr("w_data0_busy", 7'h04, 32'h0BADF00D);
        chk("busy_regwdata_stable", reg_wdata, 32'h12345678);
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        chk("ack_drops_req", {31'd0, reg_req}, 32'd0);
        rd("r_acs_after_ack", 7'h16, 32'h00000102);
        wr("w_cmd_ignored", 7'h17, 32'h00221005);
        chk("ignored_no_req", {31'd0, reg_req}, 32'd0);
        rd("r_data0_kept", 7'h04, 32'h12345678);
        wr("w_acs_clear", 7'h16, 32'h00000700);
        rd("r_acs_cleared", 7'h16, 32'h00000002);

        hart_halted = 1'b0;
        wr("w_cmd_running", 7'h17, 32'h00221005);
        chk("running_no_req", {31'd0, reg_req}, 32'd0);
        rd("r_acs_cmderr4", 7'h16, 32'h00000402);
        wr("w_acs_clear4", 7'h16, 32'h00000700);
        hart_halted = 1'b1;
        wr("w_cmd_aarsize3", 7'h17, 32'h00321005);
        chk("aarsize_no_req", {31'd0, reg_req}, 32'd0);
        rd("r_acs_cmderr2", 7'h16, 32'h00000202);
        wr("w_acs_clear2", 7'h16, 32'h00000700);

        // Resume handshake
        wr("w_resumereq", 7'h10, 32'h40000001);
        chk("resumereq_up", {31'd0, resumereq}, 32'd1);
        chk("haltreq_down", {31'd0, haltreq}, 32'd0);
        rd("r_dmcontrol_w1", 7'h10, 32'h00000001);
        hart_halted = 1'b0;
        hart_resumeack = 1'b1;
        step();
        hart_resumeack = 1'b0;
        chk("resumereq_down", {31'd0, resumereq}, 32'd0);
        rd("r_dmstatus_running", 7'h11, 32'h00030C82);

        // Deactivation clears state and blocks further data writes
        wr("w_ndmreset", 7'h10, 32'h00000003);
        chk("ndmreset_up", {31'd0, ndmreset}, 32'd1);
        wr("w_data1_pre", 7'h05, 32'h0000AAAA);
        rd("r_data1_pre", 7'h05, 32'h0000AAAA);
        wr("w_deactivate", 7'h10, 32'h00000000);
        chk("ndmreset_down", {31'd0, ndmreset}, 32'd0);
        rd("r_data1_cleared", 7'h05, 32'd0);
        wr("w_data1_inactive", 7'h05, 32'h00005555);
        rd("r_data1_inactive", 7'h05, 32'd0);

        // Latency-4 instance: reset while waiting, then held valid replays
        hart_halted = 1'b1;
        dmi_op   = 2'd1;
        dmi_addr = 7'h11;
        valid2   = 1'b1;
        sb.push_back('{rdata: 32'h00000382, resp: 2'd0, chk_rd: 1'b1});
        step();
        chk("lat4_wait_noready", {31'd0, ready2}, 32'd0);
        step();
        rst2 = 1'b1;
        #1;
        chk("lat4_rst_ready", {31'd0, ready2}, 32'd0);
        chk("lat4_rst_rdata", rdata2, 32'd0);
        step();
        chk("lat4_rst_hold", {31'd0, ready2}, 32'd0);
        rst2 = 1'b0;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (ready2) begin
                got = 1'b1;
                break;
            end
        end
        valid2 = 1'b0;
        dmi_op = 2'd0;
        chk("lat4_latency", got ? cyc : 32'hDEAD, 32'd4);
        e = sb.pop_front();
        if (got) begin
            chk("lat4_resp", {30'd0, resp2}, {30'd0, e.resp});
            chk("lat4_rdata", rdata2, e.rdata);
        end
        step();
        chk("lat4_single_strobe", {31'd0, ready2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
